// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 field widths, constants and operand classification
package fpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int TBL_AW = 10;
  localparam int SEED_W = 25;
  localparam int RCP_W = 27;
  typedef enum logic [1:0] {ZERO, NORM, INF} fclass_e;
  typedef struct packed {
    logic s;
    logic signed [9:0] e;
    logic sp;
    logic [31:0] spv;
  } ctl_t;
  function automatic fclass_e classify(input logic [EXP_W-1:0] e);
    return e == '0 ? ZERO : e == EXP_MAX ? INF : NORM;
  endfunction
endpackage

// File: rtl/finv_seed.sv
// finv_seed: reciprocal seed of 1.frac from a ROM of 1/x and 1/x^2, tangent-corrected by the low bits
module finv_seed
  import fpu_pkg::*;
(
  input  logic [MAN_W-1:0]  frac,
  output logic [SEED_W-1:0] seed
);
  localparam int N = 1 << TBL_AW;
  localparam int DW = MAN_W - TBL_AW;
  logic [SEED_W-1:0] t [N];
  logic [16:0] d [N];
  logic [TBL_AW-1:0] idx;
  logic [DW-1:0] dl;
  logic [DW+16:0] corr;
  // t = 1/x0 scaled 2^24, d = 1/x0^2 scaled 2^16, both rounded at elaboration
  for (genvar i = 0; i < N; i++) begin : g_rom
    assign t[i] = SEED_W'(((64'd1 << (SEED_W + TBL_AW)) / 64'(N + i) + 64'd1) >> 1);
    assign d[i] = 17'(((64'd1 << (17 + 2 * TBL_AW)) / 64'((N + i) * (N + i)) + 64'd1) >> 1);
  end
  assign idx = frac[MAN_W-1 -: TBL_AW];
  assign dl = frac[DW-1:0];
  assign corr = (DW+17)'(dl) * (DW+17)'(d[idx]);
  assign seed = t[idx] - SEED_W'(corr >> (MAN_W + 16 - (SEED_W - 1)));
endmodule

// File: rtl/fdiv_pipe.sv
// fdiv_pipe: 4-stage pipelined approximate binary32 divider (seed + Newton reciprocal, then multiply)
module fdiv_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);
  fclass_e c1, c2;
  logic s;
  ctl_t ctl_d, ctl1, ctl2, ctl3;
  logic [SEED_W-1:0] seed, seed1;
  logic [MAN_W-1:0] m1_1, m2_1, m1_2;
  logic [48:0] p;
  logic [30:0] e_t;
  logic [55:0] r_full;
  logic [RCP_W-1:0] r, r2;
  logic [50:0] q, q3;
  logic [24:0] top, mant;
  logic signed [9:0] ef;
  logic [31:0] y_d;
  finv_seed u_seed (.frac(x2[MAN_W-1:0]), .seed(seed));
  always_comb begin
    c1 = classify(x1[30:23]);
    c2 = classify(x2[30:23]);
    s = x1[31] ^ x2[31];
    ctl_d.s = s;
    ctl_d.e = {2'b0, x1[30:23]} - {2'b0, x2[30:23]} + 10'(BIAS);
    ctl_d.sp = c1 != NORM || c2 != NORM;
    ctl_d.spv = (c1 == c2 && c1 != NORM) ? QNAN :
                (c2 == ZERO || c1 == INF) ? {s, EXP_MAX, 23'h0} : {s, 31'h0};
  end
  // Newton step: r = s * (2 - m2*s); m2*s in Q2.47, correction kept at Q1.30
  always_comb begin
    p = 49'({1'b1, m2_1}) * 49'(seed1);
    e_t = 31'(((49'd1 << 48) - p) >> 17);
    r_full = 56'(seed1) * 56'(e_t);
    r = RCP_W'(r_full >> 28);
    q = 51'({1'b1, m1_2}) * 51'(r2);
  end
  // q3 is Q2.49; round to 24 bits at whichever position the leading one sits
  always_comb begin
    top = 25'(q3 >> 25);
    mant = top[24] ? 25'(top[24:1]) + 25'(top[0]) : 25'(top[23:0]) + 25'(q3[24]);
    ef = ctl3.e - 10'(!top[24]) + 10'(mant[24]);
    y_d = ctl3.sp ? ctl3.spv :
          ef >= 255 ? {ctl3.s, EXP_MAX, 23'h0} :
          ef <= 0 ? {ctl3.s, 31'h0} : {ctl3.s, ef[7:0], 23'(mant)};
  end
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      ctl1 <= '0;
      m1_1 <= '0;
      m2_1 <= '0;
      seed1 <= '0;
      ctl2 <= '0;
      m1_2 <= '0;
      r2 <= '0;
      ctl3 <= '0;
      q3 <= '0;
      y <= '0;
    end else begin
      ctl1 <= ctl_d;
      m1_1 <= x1[MAN_W-1:0];
      m2_1 <= x2[MAN_W-1:0];
      seed1 <= seed;
      ctl2 <= ctl1;
      m1_2 <= m1_1;
      r2 <= r;
      ctl3 <= ctl2;
      q3 <= q;
      y <= y_d;
    end
endmodule

// File: tb/tb_fdiv_pipe.sv
// tb_fdiv_pipe: random + directed stream checked against a real-arithmetic division model
module tb_fdiv_pipe;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [31:0] x1 = '0, x2 = '0;
  logic [31:0] y;
  int n_cmp = 0, n_bad = 0;
  int cur_tol = 5;
  typedef struct {logic [31:0] a; logic [31:0] b; int tol;} op_t;
  op_t pipe_q[$];
  fdiv_pipe dut (.clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .y(y));
  always #5 clk = ~clk;

  function automatic real fval(input logic [31:0] x);
    return (1.0 + real'(x[22:0]) / 8388608.0) * 2.0 ** (real'(int'(x[30:23])) - 127.0);
  endfunction

  function automatic logic [30:0] to_f32(input real q);
    logic [63:0] b;
    int fe;
    logic [24:0] m;
    b = $realtobits(q);
    fe = int'(b[62:52]) - 1023 + 127;
    m = 25'({1'b1, b[51:29]}) + 25'(b[28]);
    if (m[24]) begin
      fe++;
      m = m >> 1;
    end
    if (fe >= 255) return {8'hFF, 23'h0};
    if (fe <= 0) return 31'h0;
    return {fe[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, output bit approx);
    logic s;
    bit za, zb, ia, ib;
    s = a[31] ^ b[31];
    za = a[30:23] == 8'h00;
    zb = b[30:23] == 8'h00;
    ia = a[30:23] == 8'hFF;
    ib = b[30:23] == 8'hFF;
    approx = 1'b0;
    if ((za && zb) || (ia && ib)) return 32'h7FC00000;
    if (zb || ia) return {s, 8'hFF, 23'h0};
    if (za || ib) return {s, 31'h0};
    approx = 1'b1;
    return {s, to_f32(fval(a) / fval(b))};
  endfunction

  // zero sits next to the smallest normal, since denormals are flushed
  function automatic int key(input logic [30:0] m);
    return m == 31'h0 ? 32'h7FFFFF : int'(m);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp, input int tol);
    int d;
    n_cmp++;
    d = key(got[30:0]) - key(exp[30:0]);
    if (d < 0) d = -d;
    if ($isunknown(got) || got[31] !== exp[31] || d > tol) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (tol %0d ulp)", name, got, exp, tol);
    end
  endtask

  function automatic logic [31:0] rand_f();
    logic [7:0] e;
    int k;
    k = int'($urandom_range(0, 9));
    e = k == 0 ? 8'h00 : k == 1 ? 8'hFF : k <= 4 ? 8'($urandom_range(1, 254)) : 8'($urandom_range(110, 145));
    return {1'($urandom), e, (e == 8'h00 || e == 8'hFF) ? 23'h0 : 23'($urandom)};
  endfunction

  always @(posedge clk)
    if (rstn) pipe_q.delete();
    else begin
      pipe_q.push_back('{x1, x2, cur_tol});
      if (pipe_q.size() > 4) void'(pipe_q.pop_front());
    end

  always @(negedge clk) begin
    bit ap;
    logic [31:0] e;
    if (rstn || pipe_q.size() < 4) check("idle", y, 32'h0, 0);
    else begin
      e = ref_div(pipe_q[0].a, pipe_q[0].b, ap);
      check($sformatf("%08h/%08h", pipe_q[0].a, pipe_q[0].b), y, e, ap ? pipe_q[0].tol : 0);
    end
  end

  op_t dir[13] = '{
    '{32'h40C00000, 32'h40000000, 0}, '{32'h3F800000, 32'h40400000, 5},
    '{32'h3F800000, 32'h00000000, 0}, '{32'hBF800000, 32'h00000000, 0},
    '{32'h00000000, 32'h00000000, 0}, '{32'h40000000, 32'h7F800000, 0},
    '{32'h7F000000, 32'h00800000, 5}, '{32'h00800000, 32'h7F000000, 5},
    '{32'h7F800000, 32'hBF800000, 0}, '{32'hFF800000, 32'h7F800000, 0},
    '{32'h80000000, 32'h40A00000, 0}, '{32'hC0E00000, 32'h40000000, 5},
    '{32'h3FFFFFFF, 32'h3FFFFFFF, 5}};

  initial begin
    bit ap;
    check("model 6/2", ref_div(32'h40C00000, 32'h40000000, ap), 32'h40400000, 0);
    check("model 1/3", ref_div(32'h3F800000, 32'h40400000, ap), 32'h3EAAAAAB, 0);
    check("model -1/0", ref_div(32'hBF800000, 32'h00000000, ap), 32'hFF800000, 0);
    check("model ovf", ref_div(32'h7F000000, 32'h00800000, ap), 32'h7F800000, 0);
    check("model 7/2", ref_div(32'h40E00000, 32'h40000000, ap), 32'h40600000, 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    foreach (dir[i]) begin
      x1 = dir[i].a;
      x2 = dir[i].b;
      cur_tol = dir[i].tol;
      @(posedge clk);
      #1;
    end
    cur_tol = 5;
    for (int i = 0; i < 3000; i++) begin
      x1 = rand_f();
      x2 = rand_f();
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
    #1;
    check("async reset", y, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      x1 = rand_f();
      x2 = rand_f();
      @(posedge clk);
      #1;
    end
    x1 = '0;
    x2 = 32'h3F800000;
    repeat (6) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
